// File: rtl/tlul_reg_responder.sv
// tlul_reg_responder: bridges a single TL-UL device port onto a simple
// request/acknowledge register bus. One transaction is outstanding at a time;
// malformed requests are answered with d_error without touching the device.
//
// Optional feature: define TLUL_REG_RESPONDER_TIMEOUT_EN to add a 16-bit
// watchdog that terminates an access with d_error after TimeoutCycles cycles
// without reg_ack_i. Without the macro, an access waits indefinitely.
//
// Both TL-UL channel types are defined in tlul_pkg at the top of this file.
// AW must be in the range 3..32, and DW must be 32.

package tlul_pkg;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic [3:0]  d_user;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

endpackage

module tlul_reg_responder
  import tlul_pkg::*;
#(
  parameter int AW            = 32,
  parameter int DW            = 32,
  parameter int TimeoutCycles = 255
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  tl_h2d_t         tl_i,
  output tl_d2h_t         tl_o,
  output logic            reg_req_o,
  output logic            reg_we_o,
  output logic [AW-1:0]   reg_addr_o,
  output logic [DW-1:0]   reg_wdata_o,
  output logic [DW/8-1:0] reg_be_o,
  input  logic            reg_ack_i,
  input  logic [DW-1:0]   reg_rdata_i,
  input  logic            reg_error_i
);

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StResp
  } state_e;

  // Byte lanes covered by a request of the given size at the given offset.
  function automatic logic [3:0] size_lanes(input logic [1:0] size,
                                            input logic [1:0] offset);
    case (size)
      2'd0:    return 4'b0001 << offset;
      2'd1:    return 4'b0011 << {offset[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  // A request is legal when the opcode is supported, the size fits one word,
  // the address is size-aligned and the mask stays within the addressed lanes.
  function automatic logic req_legal(input logic [2:0] op,
                                     input logic [1:0] size,
                                     input logic [1:0] offset,
                                     input logic [3:0] mask);
    logic       op_ok;
    logic       aligned;
    logic [3:0] lanes;
    op_ok = (op == PutFullData) || (op == PutPartialData) || (op == Get);
    case (size)
      2'd0:    aligned = 1'b1;
      2'd1:    aligned = !offset[0];
      2'd2:    aligned = (offset == 2'b00);
      default: aligned = 1'b0;
    endcase
    lanes = size_lanes(size, offset);
    return op_ok && aligned && (mask != 4'h0) && ((mask & ~lanes) == 4'h0) &&
           ((op != PutFullData) || (mask == lanes));
  endfunction

  state_e          state_q, state_d;
  logic            is_put_q, is_put_d;
  logic [1:0]      size_q, size_d;
  logic [7:0]      source_q, source_d;
  logic [AW-3:0]   addr_q, addr_d;
  logic [DW/8-1:0] mask_q, mask_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            err_q, err_d;
  logic            accept;

  assign accept = (state_q == StIdle) && tl_i.a_valid;

`ifdef TLUL_REG_RESPONDER_TIMEOUT_EN
  localparam logic [15:0] TimeoutLimit = 16'(TimeoutCycles);

  logic [15:0] wdog_q, wdog_d;
  logic        wdog_expired;

  // Watchdog counts ACCESS cycles that pass without a device acknowledge.
  always_comb begin
    wdog_d       = wdog_q;
    wdog_expired = 1'b0;
    if (accept) begin
      wdog_d = 16'd0;
    end else if (state_q == StAccess && !reg_ack_i) begin
      wdog_d       = wdog_q + 16'd1;
      wdog_expired = (wdog_d == TimeoutLimit);
    end
  end

  // Watchdog counter register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wdog_q <= 16'd0;
    end else begin
      wdog_q <= wdog_d;
    end
  end
`else
  logic        wdog_expired;
  logic [15:0] unused_timeout_cycles;

  assign wdog_expired          = 1'b0;
  assign unused_timeout_cycles = 16'(TimeoutCycles);
`endif

  // Next-state and capture logic for the IDLE -> ACCESS -> RESP sequence.
  always_comb begin
    // NOTE: every _d defaults to its _q first so no path through the case leaves a latch.
    state_d  = state_q;
    is_put_d = is_put_q;
    size_d   = size_q;
    source_d = source_q;
    addr_d   = addr_q;
    mask_d   = mask_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;

    case (state_q)
      StIdle: begin
        if (accept) begin
          is_put_d = (tl_i.a_opcode == PutFullData) ||
                     (tl_i.a_opcode == PutPartialData);
          size_d   = tl_i.a_size;
          source_d = tl_i.a_source;
          addr_d   = tl_i.a_address[AW-1:2];
          mask_d   = tl_i.a_mask;
          wdata_d  = tl_i.a_data;
          if (req_legal(tl_i.a_opcode, tl_i.a_size, tl_i.a_address[1:0],
                        tl_i.a_mask)) begin
            err_d   = 1'b0;
            state_d = StAccess;
          end else begin
            err_d   = 1'b1;
            state_d = StResp;
          end
        end
      end
      StAccess: begin
        // An acknowledge on the expiry cycle still counts as a normal completion.
        if (reg_ack_i) begin
          rdata_d = reg_rdata_i;
          err_d   = reg_error_i;
          state_d = StResp;
        end else if (wdog_expired) begin
          err_d   = 1'b1;
          state_d = StResp;
        end
      end
      StResp: begin
        if (tl_i.d_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and captured-transaction registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      // NOTE: payload registers are reset as well because they drive reg_*_o directly and must read zero after reset.
      state_q  <= StIdle;
      is_put_q <= 1'b0;
      size_q   <= 2'd0;
      source_q <= 8'd0;
      addr_q   <= '0;
      mask_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments only; the _d values are already settled by the combinational block.
      state_q  <= state_d;
      is_put_q <= is_put_d;
      size_q   <= size_d;
      source_q <= source_d;
      addr_q   <= addr_d;
      mask_q   <= mask_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Channel outputs decoded from the current state and captured transaction.
  always_comb begin
    tl_o         = '0;
    tl_o.a_ready = (state_q == StIdle);
    if (state_q == StResp) begin
      tl_o.d_valid  = 1'b1;
      tl_o.d_opcode = is_put_q ? AccessAck : AccessAckData;
      tl_o.d_size   = size_q;
      tl_o.d_source = source_q;
      tl_o.d_error  = err_q;
      if (is_put_q) begin
        tl_o.d_data = 32'h0;
      end else if (err_q) begin
        tl_o.d_data = 32'hFFFF_FFFF;
      end else begin
        tl_o.d_data = rdata_q;
      end
    end
  end

  assign reg_req_o   = (state_q == StAccess);
  assign reg_we_o    = reg_req_o && is_put_q;
  assign reg_addr_o  = {addr_q, 2'b00};
  assign reg_wdata_o = wdata_q;
  assign reg_be_o    = mask_q;

  logic unused_tl_bits;
  assign unused_tl_bits = ^{tl_i.a_param, tl_i.a_address};

endmodule

// File: tb/tb_tlul_reg_responder.sv
// Testbench for tlul_reg_responder: directed vector table, reset and
// watchdog sequences, then randomized transactions checked against a
// behavioural model of the request legality and response rules.
module tb_tlul_reg_responder;
  import tlul_pkg::*;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_ni;
  tl_h2d_t     tl_i;
  tl_d2h_t     tl_o;
  logic        reg_req_o;
  logic        reg_we_o;
  logic [31:0] reg_addr_o;
  logic [31:0] reg_wdata_o;
  logic [3:0]  reg_be_o;
  logic        reg_ack_i;
  logic [31:0] reg_rdata_i;
  logic        reg_error_i;

  always #5 clk = ~clk;

  tlul_reg_responder #(
    .AW(32),
    .DW(32),
    .TimeoutCycles(TO)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .tl_i       (tl_i),
    .tl_o       (tl_o),
    .reg_req_o  (reg_req_o),
    .reg_we_o   (reg_we_o),
    .reg_addr_o (reg_addr_o),
    .reg_wdata_o(reg_wdata_o),
    .reg_be_o   (reg_be_o),
    .reg_ack_i  (reg_ack_i),
    .reg_rdata_i(reg_rdata_i),
    .reg_error_i(reg_error_i)
  );

  typedef struct packed {
    logic [2:0]  op;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] data;
    logic [7:0]  src;
    logic [7:0]  ack_dly;
    logic [31:0] rdata;
    logic        dev_err;
    logic [7:0]  dr_dly;
  } txn_t;

  typedef struct packed {
    logic        legal;
    logic [2:0]  d_op;
    logic        d_err;
    logic [31:0] d_data;
    logic [31:0] raddr;
  } exp_t;

  typedef struct packed {
    txn_t t;
    exp_t e;
  } vec_t;

  int    n_checks = 0;
  int    n_errs   = 0;
  string cur_tag  = "";

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s %s: got 0x%0h, expected 0x%0h", cur_tag, name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] op, input logic [1:0] size,
                              input logic [31:0] addr, input logic [3:0] mask,
                              input logic [31:0] data, input logic [7:0] src,
                              input logic [7:0] ack_dly, input logic [31:0] rdata,
                              input logic dev_err, input logic [7:0] dr_dly,
                              input logic legal, input logic [2:0] d_op,
                              input logic d_err, input logic [31:0] d_data,
                              input logic [31:0] raddr);
    vec_t v;
    v.t = '{op: op, size: size, addr: addr, mask: mask, data: data, src: src,
            ack_dly: ack_dly, rdata: rdata, dev_err: dev_err, dr_dly: dr_dly};
    v.e = '{legal: legal, d_op: d_op, d_err: d_err, d_data: d_data, raddr: raddr};
    return v;
  endfunction

  // Reference: legality from byte arithmetic, then the response rules.
  function automatic exp_t model(input txn_t t);
    exp_t e;
    int   bytes;
    int   off;
    int   lanes;
    bit   is_put;
    bit   op_ok;
    bit   timed_out;
    is_put = (t.op == 3'd0) || (t.op == 3'd1);
    op_ok  = is_put || (t.op == 3'd4);
    bytes  = 1 << t.size;
    off    = int'(t.addr % 4);
    lanes  = ((1 << bytes) - 1) << off;
    e.legal = op_ok && (t.size <= 2) && ((t.addr % bytes) == 0) &&
              (t.mask != 4'h0) && ((int'(t.mask) & ~lanes) == 0) &&
              ((t.op != 3'd0) || (int'(t.mask) == lanes));
    timed_out = 1'b0;
`ifdef TLUL_REG_RESPONDER_TIMEOUT_EN
    timed_out = e.legal && (int'(t.ack_dly) >= TO);
`endif
    e.d_err  = !e.legal || timed_out || t.dev_err;
    e.d_op   = is_put ? 3'd0 : 3'd1;
    e.d_data = is_put ? 32'h0 : (e.d_err ? 32'hFFFF_FFFF : t.rdata);
    e.raddr  = t.addr & ~32'h3;
    return e;
  endfunction

  function automatic txn_t rand_txn();
    txn_t       t;
    int         sel;
    logic [3:0] lanes4;
    sel    = $urandom_range(0, 9);
    t.op   = (sel < 4) ? 3'd4 : (sel < 6) ? 3'd0 : (sel < 8) ? 3'd1 : 3'($urandom);
    t.size = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
    t.addr = $urandom & 32'h0000_FFFF;
    if ($urandom_range(0, 3) != 0) t.addr = t.addr & ~((32'd1 << t.size) - 32'd1);
    lanes4 = 4'((((1 << (1 << t.size)) - 1) << (t.addr % 4)) & 'hF);
    t.mask    = ($urandom_range(0, 1) == 1) ? lanes4 : 4'($urandom);
    t.data    = $urandom;
    t.src     = 8'($urandom);
    t.ack_dly = 8'($urandom_range(0, 10));
    t.rdata   = $urandom;
    t.dev_err = ($urandom_range(0, 4) == 0);
    t.dr_dly  = 8'($urandom_range(0, 3));
    return t;
  endfunction

  // Drives one request from cycle 0 through the response handshake, acting as
  // the register device and the D-channel sink; checks every cycle.
  task automatic run_txn(input txn_t t, input exp_t e);
    int acc_cycles;
    tl_i.a_valid   = 1'b1;
    tl_i.a_opcode  = t.op;
    tl_i.a_param   = 3'd0;
    tl_i.a_size    = t.size;
    tl_i.a_source  = t.src;
    tl_i.a_address = t.addr;
    tl_i.a_mask    = t.mask;
    tl_i.a_data    = t.data;
    tl_i.d_ready   = 1'b0;
    reg_ack_i      = 1'b0;
    @(negedge clk);
    check("a_ready_accept", tl_o.a_ready, 1'b1);
    @(posedge clk); #1;
    tl_i.a_valid   = 1'b0;
    tl_i.a_address = $urandom;
    tl_i.a_data    = $urandom;
    tl_i.a_mask    = 4'($urandom);
    if (e.legal) begin
      acc_cycles = int'(t.ack_dly) + 1;
`ifdef TLUL_REG_RESPONDER_TIMEOUT_EN
      if (int'(t.ack_dly) >= TO) acc_cycles = TO;
`endif
      for (int k = 0; k < acc_cycles; k++) begin
        reg_ack_i   = (k == int'(t.ack_dly));
        reg_rdata_i = reg_ack_i ? t.rdata : $urandom;
        reg_error_i = reg_ack_i ? t.dev_err : 1'($urandom);
        @(negedge clk);
        check("reg_req", reg_req_o, 1'b1);
        check("reg_we", reg_we_o, (t.op == 3'd0) || (t.op == 3'd1));
        check("reg_addr", reg_addr_o, e.raddr);
        check("reg_be", reg_be_o, t.mask);
        check("reg_wdata", reg_wdata_o, t.data);
        check("a_ready_access", tl_o.a_ready, 1'b0);
        check("d_valid_access", tl_o.d_valid, 1'b0);
        @(posedge clk); #1;
      end
      reg_ack_i   = 1'b0;
      reg_error_i = 1'b0;
    end
    for (int k = 0; k <= int'(t.dr_dly); k++) begin
      tl_i.d_ready = (k == int'(t.dr_dly));
      @(negedge clk);
      check("d_valid", tl_o.d_valid, 1'b1);
      check("d_opcode", tl_o.d_opcode, e.d_op);
      check("d_error", tl_o.d_error, e.d_err);
      check("d_data", tl_o.d_data, e.d_data);
      check("d_size", tl_o.d_size, t.size);
      check("d_source", tl_o.d_source, t.src);
      check("d_zero_fields", {tl_o.d_param, tl_o.d_sink, tl_o.d_user}, '0);
      check("reg_req_resp", reg_req_o, 1'b0);
      check("a_ready_resp", tl_o.a_ready, 1'b0);
      @(posedge clk); #1;
    end
    tl_i.d_ready = 1'b0;
    @(negedge clk);
    check("d_valid_after", tl_o.d_valid, 1'b0);
    check("a_ready_after", tl_o.a_ready, 1'b1);
    @(posedge clk); #1;
  endtask

  // Idle cycles with the device asserting a stray acknowledge.
  task automatic stray_ack(input int n_ack);
    for (int i = 0; i < n_ack + 1; i++) begin
      reg_ack_i   = (i < n_ack);
      reg_error_i = reg_ack_i;
      reg_rdata_i = $urandom;
      @(negedge clk);
      check("idle_d_valid", tl_o.d_valid, 1'b0);
      check("idle_reg_req", reg_req_o, 1'b0);
      check("idle_a_ready", tl_o.a_ready, 1'b1);
      @(posedge clk); #1;
    end
    reg_ack_i   = 1'b0;
    reg_error_i = 1'b0;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    vec_t    vecs[11];
    tl_d2h_t rst_exp;
    txn_t    rt;

    vecs[0]  = mk(3'd4, 2'd2, 32'h10, 4'hF, 32'h0, 8'd3, 8'd0, 32'hDEAD_BEEF, 1'b0, 8'd0,
                  1'b1, 3'd1, 1'b0, 32'hDEAD_BEEF, 32'h10);
    vecs[1]  = mk(3'd1, 2'd1, 32'h22, 4'hC, 32'h1234_0000, 8'd5, 8'd0, 32'h5555_5555, 1'b0, 8'd0,
                  1'b1, 3'd0, 1'b0, 32'h0, 32'h20);
    vecs[2]  = mk(3'd4, 2'd2, 32'h13, 4'hF, 32'h0, 8'd1, 8'd0, 32'h0, 1'b0, 8'd0,
                  1'b0, 3'd1, 1'b1, 32'hFFFF_FFFF, 32'h10);
    vecs[3]  = mk(3'd5, 2'd2, 32'h10, 4'hF, 32'h0, 8'd2, 8'd0, 32'h0, 1'b0, 8'd1,
                  1'b0, 3'd1, 1'b1, 32'hFFFF_FFFF, 32'h10);
    vecs[4]  = mk(3'd0, 2'd2, 32'h08, 4'hF, 32'hA5A5_A5A5, 8'd9, 8'd2, 32'h0, 1'b1, 8'd4,
                  1'b1, 3'd0, 1'b1, 32'h0, 32'h08);
    vecs[5]  = mk(3'd0, 2'd2, 32'h04, 4'h7, 32'h1111_1111, 8'd4, 8'd0, 32'h0, 1'b0, 8'd0,
                  1'b0, 3'd0, 1'b1, 32'h0, 32'h04);
    vecs[6]  = mk(3'd4, 2'd0, 32'h01, 4'h2, 32'h0, 8'd6, 8'd1, 32'h0000_AB00, 1'b0, 8'd0,
                  1'b1, 3'd1, 1'b0, 32'h0000_AB00, 32'h00);
    vecs[7]  = mk(3'd4, 2'd0, 32'h01, 4'h1, 32'h0, 8'd7, 8'd0, 32'h0, 1'b0, 8'd0,
                  1'b0, 3'd1, 1'b1, 32'hFFFF_FFFF, 32'h00);
    vecs[8]  = mk(3'd4, 2'd3, 32'h00, 4'hF, 32'h0, 8'd8, 8'd0, 32'h0, 1'b0, 8'd0,
                  1'b0, 3'd1, 1'b1, 32'hFFFF_FFFF, 32'h00);
    vecs[9]  = mk(3'd1, 2'd2, 32'h00, 4'h0, 32'h0, 8'd10, 8'd0, 32'h0, 1'b0, 8'd0,
                  1'b0, 3'd0, 1'b1, 32'h0, 32'h00);
    vecs[10] = mk(3'd4, 2'd2, 32'h3C, 4'hF, 32'h0, 8'd11, 8'd3, 32'h1234_5678, 1'b1, 8'd2,
                  1'b1, 3'd1, 1'b1, 32'hFFFF_FFFF, 32'h3C);

    tl_i        = '0;
    reg_ack_i   = 1'b0;
    reg_rdata_i = '0;
    reg_error_i = 1'b0;
    rst_ni      = 1'b0;

    cur_tag = "reset";
    repeat (2) @(posedge clk);
    #1;
    rst_exp         = '0;
    rst_exp.a_ready = 1'b1;
    check("tl_o", tl_o, rst_exp);
    check("reg_req", reg_req_o, 1'b0);
    check("reg_we", reg_we_o, 1'b0);
    check("reg_addr", reg_addr_o, 32'h0);
    check("reg_wdata", reg_wdata_o, 32'h0);
    check("reg_be", reg_be_o, 4'h0);
    rst_ni = 1'b1;
    @(negedge clk);
    check("tl_o_released", tl_o, rst_exp);
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) begin
      cur_tag = $sformatf("vec%0d", i);
      run_txn(vecs[i].t, vecs[i].e);
    end

    // Reset pulse while the device has not yet acknowledged.
    cur_tag = "rst_access";
    tl_i.a_valid   = 1'b1;
    tl_i.a_opcode  = 3'd4;
    tl_i.a_size    = 2'd2;
    tl_i.a_address = 32'h30;
    tl_i.a_mask    = 4'hF;
    tl_i.a_source  = 8'd7;
    @(posedge clk); #1;
    tl_i.a_valid = 1'b0;
    @(negedge clk);
    check("reg_req_before", reg_req_o, 1'b1);
    @(posedge clk); #1;
    rst_ni = 1'b0;
    @(posedge clk); #1;
    rst_ni = 1'b1;
    @(negedge clk);
    check("reg_req", reg_req_o, 1'b0);
    check("d_valid", tl_o.d_valid, 1'b0);
    check("a_ready", tl_o.a_ready, 1'b1);
    @(posedge clk); #1;
    stray_ack(1);
    run_txn(vecs[0].t, vecs[0].e);

    // Reset pulse while a response is waiting for d_ready.
    cur_tag = "rst_resp";
    tl_i.a_valid  = 1'b1;
    tl_i.a_opcode = 3'd5;
    @(posedge clk); #1;
    tl_i.a_valid = 1'b0;
    @(negedge clk);
    check("d_valid_before", tl_o.d_valid, 1'b1);
    @(posedge clk); #1;
    rst_ni = 1'b0;
    @(posedge clk); #1;
    rst_ni       = 1'b1;
    tl_i.d_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("d_valid", tl_o.d_valid, 1'b0);
      check("a_ready", tl_o.a_ready, 1'b1);
      @(posedge clk); #1;
    end
    tl_i.d_ready = 1'b0;

`ifdef TLUL_REG_RESPONDER_TIMEOUT_EN
    cur_tag = "timeout";
    run_txn(mk(3'd4, 2'd2, 32'h40, 4'hF, 32'h0, 8'd9, 8'd200, 32'h0, 1'b0, 8'd1,
               1'b1, 3'd1, 1'b1, 32'hFFFF_FFFF, 32'h40).t,
            mk(3'd4, 2'd2, 32'h40, 4'hF, 32'h0, 8'd9, 8'd200, 32'h0, 1'b0, 8'd1,
               1'b1, 3'd1, 1'b1, 32'hFFFF_FFFF, 32'h40).e);
    cur_tag = "timeout_late_ack";
    stray_ack(2);
    cur_tag = "ack_on_expiry";
    run_txn(mk(3'd4, 2'd2, 32'h44, 4'hF, 32'h0, 8'd12, 8'd7, 32'h0BAD_F00D, 1'b0, 8'd0,
               1'b1, 3'd1, 1'b0, 32'h0BAD_F00D, 32'h44).t,
            mk(3'd4, 2'd2, 32'h44, 4'hF, 32'h0, 8'd12, 8'd7, 32'h0BAD_F00D, 1'b0, 8'd0,
               1'b1, 3'd1, 1'b0, 32'h0BAD_F00D, 32'h44).e);
`endif

    cur_tag = "idle_ack";
    stray_ack(2);

    for (int i = 0; i < 60; i++) begin
      cur_tag = $sformatf("rand%0d", i);
      rt = rand_txn();
      run_txn(rt, model(rt));
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
